// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked RV32I execute-stage ALU with a registered valid/ready result.
// Define ALU_MDU_EN to compile in the iterative RV32M multiply/divide unit.
module alu_exec_unit #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic            funct7_b5,
  input  logic            funct7_b0,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  logic            accept_s;
  logic            idle_s;
  logic            load_s;
  logic [XLEN-1:0] base_res_s;
  logic [XLEN-1:0] load_val_s;
  logic            out_valid_r;
  logic [XLEN-1:0] result_r;
  logic            zero_r;

  function automatic logic [XLEN-1:0] base_alu(
    input logic [1:0]      op,
    input logic [2:0]      f3,
    input logic            alt,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b
  );
    logic [XLEN-1:0] r;
    logic [SHW-1:0]  sh;
    sh = b[SHW-1:0];
    r  = {XLEN{1'b0}};
    case (op)
      2'b00: r = a + b;
      2'b01: r = a - b;
      default: begin
        case (f3)
          3'b000: r = (op == 2'b10 && alt) ? a - b : a + b;
          3'b001: r = a << sh;
          3'b010: r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
          3'b011: r = {{(XLEN-1){1'b0}}, (a < b)};
          3'b100: r = a ^ b;
          3'b101: begin
            if (alt) r = $unsigned($signed(a) >>> sh);
            else     r = a >> sh;
          end
          3'b110: r = a | b;
          3'b111: r = a & b;
          default: r = {XLEN{1'b0}};
        endcase
      end
    endcase
    return r;
  endfunction

  assign base_res_s = base_alu(alu_op, funct3, funct7_b5, op_a, op_b);
  assign in_ready   = !rst && idle_s && (!out_valid_r || out_ready);
  assign accept_s   = in_valid && in_ready;

`ifdef ALU_MDU_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10
  } state_t;

  state_t            state_r, state_nxt_s;
  logic              is_m_s, last_s;
  logic              a_sgn_s, b_sgn_s, a_neg_s, b_neg_s;
  logic [XLEN-1:0]   mag_a_s, mag_b_s, quot_s, rem_s, mdu_res_s;
  logic [XLEN:0]     mul_sum_s, div_sh_s, div_diff_s;
  logic [2*XLEN-1:0] acc_nxt_s, prod_s;
  logic [SHW-1:0]    cnt_r;
  logic [2:0]        mop_r;
  logic              neg_res_r, neg_rem_r, div0_r;
  logic [XLEN-1:0]   dvd_r, mcand_r;
  // acc_r is {hi, lo} for multiply and {remainder, quotient} for divide
  logic [2*XLEN-1:0] acc_r;

  assign is_m_s = (alu_op == 2'b10) && funct7_b0;
  assign idle_s = (state_r == ST_IDLE);
  assign last_s = (cnt_r == {SHW{1'b1}});
  assign busy   = !idle_s;

  // Operand signedness and magnitudes of the M op being offered.
  always_comb begin
    a_sgn_s = 1'b0;
    b_sgn_s = 1'b0;
    case (funct3)
      3'b001, 3'b100, 3'b110: begin a_sgn_s = 1'b1; b_sgn_s = 1'b1; end
      3'b010:                 begin a_sgn_s = 1'b1; b_sgn_s = 1'b0; end
      default:                begin a_sgn_s = 1'b0; b_sgn_s = 1'b0; end
    endcase
    a_neg_s = a_sgn_s && op_a[XLEN-1];
    b_neg_s = b_sgn_s && op_b[XLEN-1];
    if (a_neg_s) mag_a_s = -op_a;
    else         mag_a_s = op_a;
    if (b_neg_s) mag_b_s = -op_b;
    else         mag_b_s = op_b;
  end

  // One shift-add or restoring-divide step, plus the sign fixup of the final result.
  always_comb begin
    mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, mcand_r} : {(XLEN+1){1'b0}});
    div_sh_s   = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
    div_diff_s = div_sh_s - {1'b0, mcand_r};
    if (state_r == ST_DIV) begin
      if (div_diff_s[XLEN]) acc_nxt_s = {div_sh_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
      else                  acc_nxt_s = {div_diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
    end else begin
      acc_nxt_s = {mul_sum_s, acc_r[XLEN-1:1]};
    end
    if (neg_res_r) prod_s = -acc_nxt_s;
    else           prod_s = acc_nxt_s;
    if (div0_r) begin
      quot_s = {XLEN{1'b1}};
      rem_s  = dvd_r;
    end else begin
      if (neg_res_r) quot_s = -acc_nxt_s[XLEN-1:0];
      else           quot_s = acc_nxt_s[XLEN-1:0];
      if (neg_rem_r) rem_s = -acc_nxt_s[2*XLEN-1:XLEN];
      else           rem_s = acc_nxt_s[2*XLEN-1:XLEN];
    end
    case (state_r)
      ST_MUL:  mdu_res_s = (mop_r[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
      ST_DIV:  mdu_res_s = mop_r[1] ? rem_s : quot_s;
      default: mdu_res_s = {XLEN{1'b0}};
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt_s;
  end

  // FSM next state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && is_m_s) state_nxt_s = funct3[2] ? ST_DIV : ST_MUL;
        else                    state_nxt_s = ST_IDLE;
      end
      ST_MUL, ST_DIV: begin
        if (last_s) state_nxt_s = ST_IDLE;
        else        state_nxt_s = state_r;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Operand capture at accept, then one iteration per busy cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r     <= {SHW{1'b0}};
      mop_r     <= 3'b000;
      mcand_r   <= {XLEN{1'b0}};
      acc_r     <= {(2*XLEN){1'b0}};
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      div0_r    <= 1'b0;
      dvd_r     <= {XLEN{1'b0}};
    end else if (accept_s && is_m_s) begin
      cnt_r     <= {SHW{1'b0}};
      mop_r     <= funct3;
      mcand_r   <= mag_b_s;
      acc_r     <= {{XLEN{1'b0}}, mag_a_s};
      neg_res_r <= a_neg_s ^ b_neg_s;
      neg_rem_r <= a_neg_s;
      div0_r    <= (op_b == {XLEN{1'b0}});
      dvd_r     <= op_a;
    end else if (!idle_s) begin
      cnt_r <= cnt_r + {{(SHW-1){1'b0}}, 1'b1};
      acc_r <= acc_nxt_s;
    end
  end

  // Output register source: MDU completion or a single-cycle accept.
  always_comb begin
    load_s     = 1'b0;
    load_val_s = base_res_s;
    if (!idle_s && last_s) begin
      load_s     = 1'b1;
      load_val_s = mdu_res_s;
    end else if (accept_s && !is_m_s) begin
      load_s     = 1'b1;
      load_val_s = base_res_s;
    end else begin
      load_s     = 1'b0;
      load_val_s = base_res_s;
    end
  end
`else
  // M encodings fall through to the base op of the same funct3
  logic unused_funct7_b0_s;
  assign unused_funct7_b0_s = funct7_b0;
  assign idle_s     = 1'b1;
  assign busy       = 1'b0;
  assign load_s     = accept_s;
  assign load_val_s = base_res_s;
`endif

  // Output register: reload wins over drain, holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      result_r    <= {XLEN{1'b0}};
      zero_r      <= 1'b1;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      result_r    <= load_val_s;
      zero_r      <= (load_val_s == {XLEN{1'b0}});
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign zero      = zero_r;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (XLEN=32); MDU scenarios run when ALU_MDU_EN is defined.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic        funct7_b5;
  logic        funct7_b0;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7_b5(funct7_b5), .funct7_b0(funct7_b0),
    .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic b5,
                       input logic b0, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; alu_op = op; funct3 = f3; funct7_b5 = b5; funct7_b0 = b0;
    op_a = a; op_b = b;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=00000000", result); end
    checks++; if (zero !== 1'b1) begin failures++; $display("FAIL reset_zero got=%b exp=1", zero); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_rtype();
    logic [2:0]  f3_t  [10];
    logic        b5_t  [10];
    logic [31:0] exp_t [10];
    f3_t  = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
    b5_t  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_t = '{32'hFFFF_FFF4, 32'hFFFF_FFEC, 32'hFFFF_FF00, 32'h0000_0001, 32'h0000_0000,
              32'hFFFF_FFF4, 32'h0FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 32'h0000_0000};
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(2'b10, f3_t[i], b5_t[i], 1'b0, 32'hFFFF_FFF0, 32'h0000_0004);
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rtype_in_ready_%0d got=%b exp=1", i, in_ready); end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || result !== exp_t[i]) begin
        failures++; $display("FAIL rtype_%0d got valid=%b result=%h exp valid=1 result=%h", i, out_valid, result, exp_t[i]);
      end
      checks++; if (zero !== (exp_t[i] == 32'h0)) begin failures++; $display("FAIL rtype_zero_%0d got=%b exp=%b", i, zero, exp_t[i] == 32'h0); end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rtype_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_itype_branch();
    logic [1:0]  op_t  [5];
    logic [2:0]  f3_t  [5];
    logic        b5_t  [5];
    logic [31:0] a_t   [5];
    logic [31:0] b_t   [5];
    logic [31:0] exp_t [5];
    op_t  = '{2'b11, 2'b01, 2'b00, 2'b11, 2'b11};
    f3_t  = '{3'd0, 3'd0, 3'd7, 3'd5, 3'd1};
    b5_t  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    a_t   = '{32'd5, 32'd7, 32'd100, 32'h8000_0000, 32'h0000_0001};
    b_t   = '{32'd3, 32'd7, 32'd28, 32'h0000_0424, 32'hFFFF_FFE3};
    exp_t = '{32'd8, 32'd0, 32'd128, 32'hF800_0000, 32'h0000_0008};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(op_t[i], f3_t[i], b5_t[i], 1'b0, a_t[i], b_t[i]);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || result !== exp_t[i]) begin
        failures++; $display("FAIL itype_%0d got valid=%b result=%h exp valid=1 result=%h", i, out_valid, result, exp_t[i]);
      end
      checks++; if (zero !== (exp_t[i] == 32'h0)) begin failures++; $display("FAIL itype_zero_%0d got=%b exp=%b", i, zero, exp_t[i] == 32'h0); end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(2'b00, 3'd0, 1'b0, 1'b0, 32'd1, 32'd1);
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || result !== 32'd2) begin failures++; $display("FAIL bp_first got valid=%b result=%h exp valid=1 result=00000002", out_valid, result); end
    drive(2'b00, 3'd0, 1'b0, 1'b0, 32'd2, 32'd3);
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== 32'd2) begin
        failures++; $display("FAIL bp_hold_%0d got in_ready=%b valid=%b result=%h exp in_ready=0 valid=1 result=00000002", i, in_ready, out_valid, result);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || result !== 32'd5) begin failures++; $display("FAIL bp_second got valid=%b result=%h exp valid=1 result=00000005", out_valid, result); end
    drive(2'b00, 3'd0, 1'b0, 1'b0, 32'd10, 32'd20);
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || result !== 32'd30) begin failures++; $display("FAIL bp_third got valid=%b result=%h exp valid=1 result=0000001e", out_valid, result); end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_m_select();
    out_ready = 1'b1;
    // I-type with instr[25] set is never an M op
    drive(2'b11, 3'd0, 1'b0, 1'b1, 32'd6, 32'd7);
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || result !== 32'd13 || busy !== 1'b0) begin failures++; $display("FAIL mselect_itype got valid=%b result=%h busy=%b exp valid=1 result=0000000d busy=0", out_valid, result, busy); end
`ifndef ALU_MDU_EN
    drive(2'b10, 3'd0, 1'b0, 1'b1, 32'd6, 32'd7);
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || result !== 32'd13 || busy !== 1'b0) begin failures++; $display("FAIL mselect_mul_as_add got valid=%b result=%h busy=%b exp valid=1 result=0000000d busy=0", out_valid, result, busy); end
    drive(2'b10, 3'd4, 1'b0, 1'b1, 32'd6, 32'd7);
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || result !== 32'd1 || busy !== 1'b0) begin failures++; $display("FAIL mselect_div_as_xor got valid=%b result=%h busy=%b exp valid=1 result=00000001 busy=0", out_valid, result, busy); end
`endif
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

`ifdef ALU_MDU_EN
  task automatic run_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int busy_cnt, output int rdy_cnt, output logic [31:0] res);
    drive(2'b10, f3, 1'b0, 1'b1, a, b);
    @(posedge clk); #1;
    in_valid = 1'b0; op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom);
    lat = 1; busy_cnt = 0; rdy_cnt = 0;
    while (!out_valid && lat < 100) begin
      if (busy) busy_cnt++;
      if (in_ready) rdy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    res = result;
  endtask

  task automatic test_mdu();
    logic [2:0]  f3_t  [10];
    logic [31:0] a_t   [10];
    logic [31:0] b_t   [10];
    logic [31:0] exp_t [10];
    int lat, bc, rc;
    logic [31:0] res;
    f3_t  = '{3'd0, 3'd3, 3'd1, 3'd4, 3'd6, 3'd5, 3'd6, 3'd4, 3'd7, 3'd6};
    a_t   = '{32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
              32'd5, 32'h8000_0000, 32'h8000_0000, 32'd100, 32'hFFFF_FFF9};
    b_t   = '{32'h9ABC_DEF0, 32'h9ABC_DEF0, 32'd3, 32'd2, 32'd2,
              32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd0};
    exp_t = '{32'h242D_2080, 32'h0B00_EA4E, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
              32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFF9};
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      run_m(f3_t[i], a_t[i], b_t[i], lat, bc, rc, res);
      checks++; if (res !== exp_t[i]) begin failures++; $display("FAIL mdu_result_%0d got=%h exp=%h", i, res, exp_t[i]); end
      checks++; if (lat !== 33) begin failures++; $display("FAIL mdu_latency_%0d got=%0d exp=33", i, lat); end
      checks++; if (bc !== 32 || rc !== 0) begin failures++; $display("FAIL mdu_busy_%0d got busy_cycles=%0d in_ready_cycles=%0d exp 32 and 0", i, bc, rc); end
      checks++; if (zero !== (exp_t[i] == 32'h0) || busy !== 1'b0) begin failures++; $display("FAIL mdu_zero_idle_%0d got zero=%b busy=%b exp zero=%b busy=0", i, zero, busy, exp_t[i] == 32'h0); end
    end
    @(posedge clk); #1;
  endtask
`endif

  task automatic test_reset_mid_op();
    int seen;
`ifdef ALU_MDU_EN
    out_ready = 1'b1;
    drive(2'b10, 3'd4, 1'b0, 1'b1, 32'd100, 32'd7);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midop_busy_before got=%b exp=1", busy); end
`else
    out_ready = 1'b0;
    drive(2'b00, 3'd0, 1'b0, 1'b0, 32'd1, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL midop_valid_before got=%b exp=1", out_valid); end
`endif
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || zero !== 1'b1) begin failures++; $display("FAIL midop_reset got valid=%b busy=%b zero=%b exp 0 0 1", out_valid, busy, zero); end
    rst = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midop_idle_after got in_ready=%b exp=1", in_ready); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL midop_no_result got=%0d active cycles exp=0", seen); end
    drive(2'b00, 3'd0, 1'b0, 1'b0, 32'd3, 32'd4);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || result !== 32'd7) begin failures++; $display("FAIL midop_add_after got valid=%b result=%h exp valid=1 result=00000007", out_valid, result); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; alu_op = 2'b00; funct3 = 3'b000;
    funct7_b5 = 1'b0; funct7_b0 = 1'b0; op_a = 32'h0; op_b = 32'h0;
    test_reset();
    test_rtype();
    test_itype_branch();
    test_backpressure();
    test_m_select();
`ifdef ALU_MDU_EN
    test_mdu();
`endif
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
